// File: rtl/diff_obuf_pattern_tx_if.sv
// Pattern-select, switch and hold inputs, plus the tick, pattern and differential
// outputs of diff_obuf_pattern_tx, bundled as one port.
interface diff_obuf_pattern_tx_if #(
    parameter int unsigned N_CH = 2
);
    logic [1:0]      mode;
    logic [N_CH-1:0] sw;
    logic            hold;
    logic            tick;
    logic [N_CH-1:0] pat;
    logic [N_CH-1:0] diff_p;
    logic [N_CH-1:0] diff_n;

    modport master (
        output mode, sw, hold,
        input  tick, pat, diff_p, diff_n
    );

    modport slave (
        input  mode, sw, hold,
        output tick, pat, diff_p, diff_n
    );
endinterface

// File: rtl/diff_obuf_pattern_tx.sv
// N-channel OBUFDS driver fed from a run-time selectable pattern register (pass/walk/count/toggle).
// Define DIFF_OBUF_PRBS_EN to turn mode 3 into a PRBS7 (x^7+x^6+1) generator instead of a toggle.
module diff_obuf_pattern_tx #(
    parameter int unsigned      N_CH       = 2,
    parameter int unsigned      DIV_W      = 24,
    parameter logic [DIV_W-1:0] DIV_MAX    = DIV_W'(9_999_999),
    parameter string            IOSTANDARD = "DIFF_SSTL135",
    parameter string            SLEW       = "FAST"
) (
    input logic                   clk,
    input logic                   rst,
    diff_obuf_pattern_tx_if.slave bus
);
    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_WALK  = 2'd1;
    localparam logic [1:0] MODE_COUNT = 2'd2;
    localparam logic [1:0] MODE_ALT   = 2'd3;

    localparam logic [N_CH-1:0] PAT_ONE = N_CH'(1);

    logic [N_CH-1:0]  sw_meta;
    logic [N_CH-1:0]  sw_sync;
    logic [N_CH-1:0]  pat_q;
    logic [N_CH-1:0]  pat_next;
    logic [N_CH-1:0]  seed;
    logic [N_CH-1:0]  alt_seed;
    logic [N_CH-1:0]  alt_next;
    logic [1:0]       mode_q;
    logic [DIV_W-1:0] div_q;
    logic             tick;
    logic             restart;
    logic             step;

    assign tick    = (div_q == DIV_MAX);
    assign restart = (bus.mode != mode_q);
    assign step    = tick && !bus.hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= bus.sw;
            sw_sync <= sw_meta;
        end
    end

    // A mode change realigns the divider so the new pattern gets a full tick period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_PASS;
            div_q  <= '0;
        end else begin
            mode_q <= bus.mode;
            if (restart || tick) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

`ifdef DIFF_OBUF_PRBS_EN
    localparam logic [6:0] LFSR_SEED = 7'h7F;

    logic [6:0] lfsr_q;
    logic [6:0] lfsr_next;

    function automatic logic [N_CH-1:0] lfsr_to_pat(input logic [6:0] l);
        logic [N_CH-1:0] p;
        p = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            p[i] = l[i % 7];
        end
        return p;
    endfunction

    assign lfsr_next = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    assign alt_seed  = lfsr_to_pat(LFSR_SEED);
    assign alt_next  = lfsr_to_pat(lfsr_next);

    // Reseeding on every mode change keeps the entry into PRBS deterministic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else if (restart) begin
            lfsr_q <= LFSR_SEED;
        end else if ((mode_q == MODE_ALT) && step) begin
            lfsr_q <= lfsr_next;
        end
    end
`else
    assign alt_seed = '0;
    assign alt_next = ~pat_q;
`endif

    always_comb begin
        seed = '0;
        case (bus.mode)
            MODE_PASS:  seed = sw_sync;
            MODE_WALK:  seed = PAT_ONE;
            MODE_COUNT: seed = '0;
            default:    seed = alt_seed;
        endcase
    end

    // Restart takes priority over a tick landing in the same cycle.
    always_comb begin
        pat_next = pat_q;
        if (restart) begin
            pat_next = seed;
        end else begin
            case (mode_q)
                MODE_PASS: pat_next = sw_sync;
                MODE_WALK: begin
                    if (step) pat_next = (pat_q << 1) | (pat_q >> (N_CH - 1));
                end
                MODE_COUNT: begin
                    if (step) pat_next = pat_q + N_CH'(1);
                end
                default: begin
                    if (step) pat_next = alt_next;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q <= '0;
        end else begin
            pat_q <= pat_next;
        end
    end

    assign bus.tick = tick;
    assign bus.pat  = pat_q;

    // Vendor OBUFDS in synthesis; an equivalent complementary pair everywhere else.
    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
`ifdef SYNTHESIS
        OBUFDS #(
            .IOSTANDARD(IOSTANDARD),
            .SLEW      (SLEW)
        ) u_obufds (
            .O (bus.diff_p[i]),
            .OB(bus.diff_n[i]),
            .I (pat_q[i])
        );
`else
        if ((IOSTANDARD == "") || (SLEW == "")) begin : g_no_attr
        end
        assign bus.diff_p[i] = pat_q[i];
        assign bus.diff_n[i] = ~pat_q[i];
`endif
    end
endmodule

// File: tb/tb_diff_obuf_pattern_tx.sv
// Randomised scoreboard bench for diff_obuf_pattern_tx (N_CH=4, DIV_MAX=3).
// Honours DIFF_OBUF_PRBS_EN the same way as the design.
module tb_diff_obuf_pattern_tx;
    localparam int unsigned      N_CH    = 4;
    localparam int unsigned      DIV_W   = 4;
    localparam logic [DIV_W-1:0] DIV_MAX = 4'd3;
    localparam int               PERIOD  = int'(DIV_MAX) + 1;

    typedef struct packed {
        logic [N_CH-1:0] pat;
        logic            tick;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    diff_obuf_pattern_tx_if #(.N_CH(N_CH)) bus ();

    diff_obuf_pattern_tx #(
        .N_CH      (N_CH),
        .DIV_W     (DIV_W),
        .DIV_MAX   (DIV_MAX),
        .IOSTANDARD("DIFF_SSTL135"),
        .SLEW      ("FAST")
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_vectors     = 0;
    int   n_miscompares = 0;

    // Reference state: divider position, current mode, and number of pattern advances since entry.
    int              m_pos;
    int              m_adv;
    logic [1:0]      m_mode;
    logic [N_CH-1:0] m_sw_hist[$];

`ifdef DIFF_OBUF_PRBS_EN
    logic [6:0] prbs_tbl[127];
`endif

    function automatic logic [N_CH-1:0] pattern_of(input logic [1:0] mode, input int adv);
        logic [N_CH-1:0] p;
        p = '0;
        case (mode)
            2'd1: p = N_CH'(1) << (adv % int'(N_CH));
            2'd2: p = N_CH'(adv % (1 << N_CH));
            2'd3: begin
`ifdef DIFF_OBUF_PRBS_EN
                for (int i = 0; i < int'(N_CH); i++) p[i] = prbs_tbl[adv % 127][i % 7];
`else
                p = ((adv % 2) == 1) ? '1 : '0;
`endif
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    function automatic logic [N_CH-1:0] rand_sw();
        return N_CH'($urandom);
    endfunction

    task automatic model_reset();
        m_pos  = 0;
        m_adv  = 0;
        m_mode = 2'd0;
        m_sw_hist.delete();
        m_sw_hist.push_back('0);
        m_sw_hist.push_back('0);
    endtask

    task automatic model_step(input logic [1:0] m, input logic [N_CH-1:0] s, input logic h);
        logic            tick_before;
        logic [N_CH-1:0] sw_delayed;
        exp_t            e;
        tick_before = (m_pos == int'(DIV_MAX));
        m_sw_hist.push_back(s);
        sw_delayed = m_sw_hist.pop_front();
        if (m != m_mode) begin
            m_mode = m;
            m_pos  = 0;
            m_adv  = 0;
        end else begin
            m_pos = tick_before ? 0 : m_pos + 1;
            if (tick_before && !h) m_adv++;
        end
        e.pat  = (m_mode == 2'd0) ? sw_delayed : pattern_of(m_mode, m_adv);
        e.tick = (m_pos == int'(DIV_MAX));
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e, input string name);
        n_vectors += 4;
        if (bus.pat !== e.pat) begin
            n_miscompares++;
            $display("[TB] FAIL %s.pat @%0t: got %b, expected %b", name, $time, bus.pat, e.pat);
        end
        if (bus.diff_p !== e.pat) begin
            n_miscompares++;
            $display("[TB] FAIL %s.diff_p @%0t: got %b, expected %b", name, $time, bus.diff_p, e.pat);
        end
        if (bus.diff_n !== ~e.pat) begin
            n_miscompares++;
            $display("[TB] FAIL %s.diff_n @%0t: got %b, expected %b", name, $time, bus.diff_n, ~e.pat);
        end
        if (bus.tick !== e.tick) begin
            n_miscompares++;
            $display("[TB] FAIL %s.tick @%0t: got %b, expected %b", name, $time, bus.tick, e.tick);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [N_CH-1:0] s, input logic h);
        @(negedge clk);
        rst      = 1'b0;
        bus.mode = m;
        bus.sw   = s;
        bus.hold = h;
        model_step(m, s, h);
    endtask

    // Asserted between edges so the immediate check proves the clear is asynchronous.
    task automatic applyReset(input int cycles);
        exp_t r;
        r.pat  = '0;
        r.tick = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1 checkOutput(r, "async_reset");
        exp_q.push_back(r);
        for (int c = 1; c < cycles; c++) begin
            @(negedge clk);
            exp_q.push_back(r);
        end
    endtask

    task automatic switchOnTick(input logic [1:0] from_m, input logic [1:0] to_m);
        int guard;
        guard = 0;
        while ((m_pos != int'(DIV_MAX)) && (guard < 4 * PERIOD)) begin
            applyStimulus(from_m, rand_sw(), 1'b0);
            guard++;
        end
        applyStimulus(to_m, rand_sw(), 1'b0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front(), "cycle");
        end
    end

    initial begin
        #200000;
        n_miscompares++;
        $display("[TB] FAIL watchdog: got timeout at %0t, expected completion", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
`ifdef DIFF_OBUF_PRBS_EN
        begin
            logic [6:0] l;
            l = 7'h7F;
            for (int k = 0; k < 127; k++) begin
                prbs_tbl[k] = l;
                l = {l[5:0], l[6] ^ l[5]};
            end
        end
`endif
        bus.mode = 2'd0;
        bus.sw   = '0;
        bus.hold = 1'b0;
        model_reset();

        $display("[TB] reset and pass mode");
        applyReset(5);
        repeat (6) applyStimulus(2'd0, 4'b0000, 1'b0);
        repeat (6) applyStimulus(2'd0, 4'b0001, 1'b0);
        repeat (6) applyStimulus(2'd0, 4'b0010, 1'b1);
        repeat (10) applyStimulus(2'd0, rand_sw(), 1'($urandom));

        $display("[TB] walk, switch to count on a tick, hold");
        repeat (5 * PERIOD + 2) applyStimulus(2'd1, rand_sw(), 1'b0);
        switchOnTick(2'd1, 2'd2);
        repeat (18 * PERIOD) applyStimulus(2'd2, rand_sw(), 1'b0);
        repeat (3 * PERIOD) applyStimulus(2'd2, rand_sw(), 1'b1);
        repeat (4 * PERIOD) applyStimulus(2'd2, rand_sw(), 1'b0);

        $display("[TB] reset mid-pattern");
        applyReset(3);
        repeat (3 * PERIOD) applyStimulus(2'd2, rand_sw(), 1'b0);

        $display("[TB] mode 3 over a full PRBS period");
        repeat (130 * PERIOD) applyStimulus(2'd3, rand_sw(), 1'b0);

        $display("[TB] random mode/hold/sw mix");
        begin
            logic [1:0] cur_mode;
            cur_mode = 2'd3;
            for (int n = 0; n < 400; n++) begin
                if ($urandom_range(0, 15) == 0) cur_mode = 2'($urandom);
                applyStimulus(cur_mode, rand_sw(), $urandom_range(0, 3) == 0);
            end
        end

        repeat (3) @(negedge clk);
        n_vectors++;
        if (exp_q.size() != 0) begin
            n_miscompares++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
